// File: rtl/add_seq_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package add_seq_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIBBLE_W = 4;
endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice; c3 is the carry into bit 3 for overflow detection.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       c3
);
  logic [3:0] g, p;
  logic       c1, c2;

  assign g = a & b;
  assign p = a | b;

  // Every carry is flattened from g/p and cin; none ripples through an earlier carry.
  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = a ^ b ^ {c3, c2, c1, cin};
endmodule

// File: rtl/wide_add_seq.sv
// WIDTH-bit add/subtract computed one nibble per cycle through a single registered-carry CLA slice.
module wide_add_seq
  import add_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);
  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = $clog2(NIB);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d, sum_q, sum_d;
  logic               carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] sl_a, sl_b, sl_sum;
  logic                sl_cout, sl_c3, last;

  assign sl_a = opa_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign sl_b = opb_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign last = (idx_q == IDX_W'(NIB - 1));

  cla4_slice u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout),
    .c3   (sl_c3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        // Subtraction becomes a + ~b + 1 by inverting B and forcing the carry-in.
        opa_d   = a;
        opb_d   = sub ? ~b : b;
        carry_d = sub ? 1'b1 : cin;
        idx_d   = '0;
        sum_d   = '0;
        cout_d  = 1'b0;
        ovf_d   = 1'b0;
      end
      RUN: begin
        sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = sl_sum;
        carry_d = sl_cout;
        idx_d   = idx_q + 1'b1;
        if (last) begin
          idx_d  = '0;
          cout_d = sl_cout;
          ovf_d  = sl_c3 ^ sl_cout;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == DONE);
    sum       = sum_q;
    cout      = cout_q;
    overflow  = ovf_q;
  end
endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq: directed vectors, backpressure, async reset and a randomized run vs. an arithmetic model.
module tb_wide_add_seq;
  localparam int W   = 32;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow, busy;
  logic [W-1:0] a, b, sum;

  int tests = 0, fails = 0, hs = 0, ops_done = 0;

  always #5 clk = ~clk;

  wide_add_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .busy(busy)
  );

  always @(posedge clk) if (!rst && out_valid && out_ready) hs++;

  // Reference: plain wide arithmetic; returns {overflow, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
    logic [W-1:0] yo;
    logic [W:0]   r;
    logic         ov;
    yo = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yo} + {{W{1'b0}}, (s ? 1'b1 : ci)};
    ov = (x[W-1] == yo[W-1]) && (r[W-1] != x[W-1]);
    return {ov, r[W], r[W-1:0]};
  endfunction

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
    @(posedge clk); #1;
    in_valid = 1'b1; a = x; b = y; cin = ci; sub = s;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_done(output int lat, output bit rdy_seen);
    lat = 0; rdy_seen = 1'b0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_op(input int stall);
    repeat (stall) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    ops_done++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    tests++;
    if (sum !== '0 || cout !== 1'b0 || overflow !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: sum=%h cout=%b ovf=%b ov=%b busy=%b rdy=%b, want 0 0 0 0 0 1",
               sum, cout, overflow, out_valid, busy, in_ready);
    end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_vector(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic ci, input logic s,
                             input logic [W-1:0] es, input logic ec, input logic eo);
    int lat; bit rs;
    start_op(x, y, ci, s);
    wait_done(lat, rs);
    tests++;
    if (lat != NIB || rs) begin
      fails++;
      $display("FAIL %s latency: got %0d ready_seen=%b, want %0d 0", nm, lat, rs, NIB);
    end
    tests++;
    if (sum !== es || cout !== ec || overflow !== eo || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s result: got %h c=%b o=%b busy=%b, want %h c=%b o=%b busy=1",
               nm, sum, cout, overflow, busy, es, ec, eo);
    end
    release_op(0);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s release: out_valid=%b in_ready=%b, want 0 1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int lat; bit rs;
    logic [W-1:0] x, y;
    logic [W+1:0] e;
    x = $urandom; y = $urandom;
    e = model(x, y, 1'b1, 1'b0);
    start_op(x, y, 1'b1, 1'b0);
    wait_done(lat, rs);
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom; in_valid = 1'($urandom);
      @(posedge clk); #1;
      tests++;
      if ({overflow, cout, sum} !== e || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL backpressure cyc%0d: got o=%b c=%b %h rdy=%b ov=%b, want %b %b %h 0 1",
                 i, overflow, cout, sum, in_ready, out_valid, e[W+1], e[W], e[W-1:0]);
      end
    end
    in_valid = 1'b0;
    release_op(0);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL backpressure release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    x = $urandom; y = $urandom;
    e = model(x, y, 1'b0, 1'b1);
    start_op(x, y, 1'b0, 1'b1);
    wait_done(lat, rs);
    tests++;
    if ({overflow, cout, sum} !== e || lat != NIB) begin
      fails++;
      $display("FAIL backpressure next: got %b %b %h lat=%0d, want %b %b %h lat=%0d",
               overflow, cout, sum, lat, e[W+1], e[W], e[W-1:0], NIB);
    end
    release_op(0);
  endtask

  task automatic test_reset_mid();
    int lat; bit rs;
    start_op(32'hDEADBEEF, 32'h13579BDF, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    tests++;
    if (sum !== '0 || cout !== 1'b0 || overflow !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid: sum=%h cout=%b ovf=%b ov=%b busy=%b rdy=%b, want 0 0 0 0 0 1",
               sum, cout, overflow, out_valid, busy, in_ready);
    end
    @(posedge clk); #1; rst = 1'b0;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid ready: in_ready=%b, want 1", in_ready);
    end
    start_op(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    wait_done(lat, rs);
    tests++;
    if (sum !== 32'h23456789 || cout !== 1'b0 || overflow !== 1'b0 || lat != NIB) begin
      fails++;
      $display("FAIL reset_mid fresh: got %h c=%b o=%b lat=%0d, want 23456789 0 0 lat=%0d",
               sum, cout, overflow, lat, NIB);
    end
    release_op(0);
  endtask

  task automatic test_random();
    int lat; bit rs; int bad = 0;
    logic [W-1:0] x, y;
    logic ci, s;
    logic [W+1:0] e;
    for (int n = 0; n < 1000; n++) begin
      x = $urandom; y = $urandom; ci = 1'($urandom); s = 1'($urandom);
      case ($urandom_range(0, 7))
        0: x = '1;
        1: y = '0;
        2: x = {1'b1, {(W-1){1'b0}}};
        default: ;
      endcase
      e = model(x, y, ci, s);
      start_op(x, y, ci, s);
      wait_done(lat, rs);
      tests++;
      if ({overflow, cout, sum} !== e || lat != NIB || rs) begin
        fails++; bad++;
        if (bad <= 10)
          $display("FAIL random op%0d a=%h b=%h ci=%b sub=%b: got %b %b %h lat=%0d, want %b %b %h lat=%0d",
                   n, x, y, ci, s, overflow, cout, sum, lat, e[W+1], e[W], e[W-1:0], NIB);
      end
      release_op($urandom_range(0, 3));
    end
  endtask

  task automatic test_handshakes();
    tests++;
    if (hs != ops_done) begin
      fails++;
      $display("FAIL handshakes: got %0d, want %0d", hs, ops_done);
    end
  endtask

  initial begin
    test_reset();
    test_vector("add_carry_nib", 32'h0000000F, 32'h00000001, 1'b0, 1'b0, 32'h00000010, 1'b0, 1'b0);
    test_vector("add_wrap",      32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    test_vector("add_ovf",       32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    test_vector("sub_neg",       32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    test_vector("sub_ovf",       32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    test_vector("add_cin",       32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0);
    test_backpressure();
    test_reset_mid();
    test_random();
    test_handshakes();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wide_add_seq.md
Name: wide_add_seq

Overview:
- Multi-cycle sequencer that adds or subtracts two WIDTH-bit operands by stepping a registered-carry 4-bit carry-lookahead slice over the operand, one nibble per cycle, least-significant nibble first.
- Sits between a requester (valid/ready in) and a consumer (valid/ready out) in the NPC datapath.
- Replaces a WIDTH-bit ripple/CLA tree with one small slice plus a sequencer.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 4 and ≥ 8.
- NIB, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; ignored when sub=1
- sub  in  1  1 = a - b (two's complement), 0 = a + b + cin
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out; for sub, 1 = no borrow
- overflow  out  1  signed overflow
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset: rst=1 asynchronously forces state to IDLE.
  - Output values under reset: sum=0, cout=0, overflow=0, out_valid=0, busy=0, in_ready=1.
  - Internal state cleared: nibble index=0, carry=0, operand registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at an edge:
    - Latch a into opa.
    - Latch opb = sub ? ~b : b.
    - Set carry = sub ? 1 : cin.
    - Set idx=0, clear sum/cout/overflow, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, the slice combinationally adds opa[4*idx+:4], opb[4*idx+:4] and carry.
  - At the edge: sum[4*idx+:4] takes the slice sum, carry takes the slice cout, idx increments.
  - When idx==NIB-1 at the edge:
    - Also register cout = slice cout.
    - Register overflow = slice c3 XOR slice cout, where c3 is the carry into the top bit.
    - Go to DONE.
- DONE:
  - out_valid=1; sum, cout and overflow are held stable.
  - On out_ready, go to IDLE at the edge, with out_valid=0 the next cycle.
  - in_valid is ignored; no overlap of accept and deliver.
- Latency: out_valid rises exactly NIB cycles after the accepting edge (8 for WIDTH=32).
  - Minimum initiation interval is NIB+2 cycles.
- Backpressure: DONE may last indefinitely; outputs must not change while out_valid && !out_ready.
- Operands are captured at accept; changes on a/b/cin/sub during RUN or DONE have no effect.
- Outputs are fully registered; no combinational path from any input to any output, except through rst.
- Reset mid-operation: immediate return to IDLE with the reset values above; the partial result is discarded and never presented.
- Arithmetic is modulo 2^WIDTH.
  - sub: the result equals a + ~b + 1.
  - Overflow is signed, from the top nibble only.

Decomposition:
- Shared package (add_seq_pkg):
  - state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - NIBBLE_W=4 constant.
- One sub-module: cla4_slice, a purely combinational 4-bit carry-lookahead adder.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: sum[3:0], cout, c3.
  - Uses generate/propagate lookahead: g=a&b, p=a|b, sum=a^b^c.
- The sequencer owns all registers.

Test Plan:
- WIDTH=32, a=0x0000000F, b=0x00000001, cin=0, sub=0 → sum=0x00000010, cout=0, overflow=0; out_valid exactly 8 cycles after accept; in_ready=0 throughout.
- a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1, overflow=0. a=0x7FFFFFFF, b=1 → sum=0x80000000, cout=0, overflow=1.
- sub=1, a=5, b=7, cin=1 (must be ignored) → sum=0xFFFFFFFE, cout=0, overflow=0. a=0x80000000, b=1 → sum=0x7FFFFFFF, cout=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling a/b/in_valid → sum/cout/overflow unchanged, in_ready=0. Then out_ready=1 → IDLE next cycle, and a new request is accepted.
- Assert rst asynchronously mid-RUN (idx=3) → outputs go to reset values without waiting for a clock edge. After release, in_ready=1 and a fresh request (0x12345678+0x11111111) yields 0x23456789.
- Randomised sequence of 1000 ops with random sub/cin/out_ready stalls vs. reference model → every result matches, and no extra or missing out_valid handshakes.
